// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcodes, ALUOp encodings and the control bundle.
// Used by the ID-stage main decoder and by the EX-stage ALU control decoder.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_MEM  = 3'b000;
  localparam logic [2:0] ALUOP_BR   = 3'b001;
  localparam logic [2:0] ALUOP_R    = 3'b010;
  localparam logic [2:0] ALUOP_ANDI = 3'b011;
  localparam logic [2:0] ALUOP_ORI  = 3'b100;
  localparam logic [2:0] ALUOP_SLTI = 3'b111;

  typedef struct packed {
    logic [2:0] aluop;
    logic       regdst;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       regwrite;
    logic       memtoreg;
  } ctrl_t;

  function automatic ctrl_t make_ctrl(
    input logic [2:0] aluop,
    input logic regdst, input logic alusrc, input logic memread,
    input logic memwrite, input logic branch, input logic regwrite,
    input logic memtoreg
  );
    ctrl_t c;
    c.aluop    = aluop;
    c.regdst   = regdst;
    c.alusrc   = alusrc;
    c.memread  = memread;
    c.memwrite = memwrite;
    c.branch   = branch;
    c.regwrite = regwrite;
    c.memtoreg = memtoreg;
    return c;
  endfunction

  localparam ctrl_t CTRL_NONE = make_ctrl(ALUOP_MEM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

endpackage

// File: rtl/main_decoder.sv
// Combinational main control decoder: opcode -> control bundle plus
// illegal/jump flags and whether rt is read as a source operand.
module main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal,
  output logic       jump,
  output logic       rt_is_source
);

  // opcode decode table
  always_comb begin
    ctrl         = CTRL_NONE;
    illegal      = 1'b0;
    jump         = 1'b0;
    rt_is_source = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl         = make_ctrl(ALUOP_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rt_is_source = 1'b1;
      end
      OP_LW:   ctrl = make_ctrl(ALUOP_MEM, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      OP_SW: begin
        ctrl         = make_ctrl(ALUOP_MEM, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rt_is_source = 1'b1;
      end
      OP_BEQ: begin
        ctrl         = make_ctrl(ALUOP_BR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rt_is_source = 1'b1;
      end
      OP_ADDI: ctrl = make_ctrl(ALUOP_MEM,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      OP_ANDI: ctrl = make_ctrl(ALUOP_ANDI, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      OP_ORI:  ctrl = make_ctrl(ALUOP_ORI,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      OP_SLTI: ctrl = make_ctrl(ALUOP_SLTI, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      OP_J:    jump = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_control.sv
// Main control decode, load-use hazard detection and the ID/EX control register.
// Optional saturating stall/bubble counters are enabled with ID_EX_PERF_CNT_EN.
module id_ex_control
  import mips_ctrl_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [5:0]      id_opcode,
  input  logic [5:0]      id_funct,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic [RA_W-1:0] id_rd,
  input  logic            flush,
  output logic            stall,
  output logic            id_jump,
  output logic [2:0]      ex_aluop,
  output logic [5:0]      ex_funct,
  output logic            ex_regdst,
  output logic            ex_alusrc,
  output logic [RA_W-1:0] ex_rs,
  output logic [RA_W-1:0] ex_rt,
  output logic [RA_W-1:0] ex_rd,
  output logic            m_memread,
  output logic            m_memwrite,
  output logic            m_branch,
  output logic            wb_regwrite,
  output logic            wb_memtoreg,
`ifdef ID_EX_PERF_CNT_EN
  output logic            ex_illegal,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`else
  output logic            ex_illegal
`endif
);

  localparam logic [RA_W-1:0] REG_ZERO = {RA_W{1'b0}};

  ctrl_t dec_ctrl_s;
  logic  dec_illegal_s;
  logic  dec_jump_s;
  logic  dec_rt_src_s;

  ctrl_t           ctrl_r;
  logic            illegal_r;
  logic [5:0]      funct_r;
  logic [RA_W-1:0] rs_r;
  logic [RA_W-1:0] rt_r;
  logic [RA_W-1:0] rd_r;

  logic hazard_s;
  logic stall_s;
  logic bubble_s;

  main_decoder u_main_decoder (
    .opcode       (id_opcode),
    .ctrl         (dec_ctrl_s),
    .illegal      (dec_illegal_s),
    .jump         (dec_jump_s),
    .rt_is_source (dec_rt_src_s)
  );

  // load in ID/EX whose destination feeds a source of the ID instruction; $0 never hazards
  always_comb begin
    hazard_s = 1'b0;
    if (ctrl_r.memread && (rt_r != REG_ZERO) &&
        ((rt_r == id_rs) || ((rt_r == id_rt) && dec_rt_src_s))) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign stall_s  = id_valid & hazard_s & ~flush;
  assign bubble_s = flush | stall_s | ~id_valid;
  assign stall    = stall_s;
  assign id_jump  = id_valid & dec_jump_s;

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r    <= CTRL_NONE;
      illegal_r <= 1'b0;
      funct_r   <= 6'b000000;
      rs_r      <= REG_ZERO;
      rt_r      <= REG_ZERO;
      rd_r      <= REG_ZERO;
    end else if (bubble_s) begin
      ctrl_r    <= CTRL_NONE;
      illegal_r <= 1'b0;
      funct_r   <= 6'b000000;
      rs_r      <= REG_ZERO;
      rt_r      <= REG_ZERO;
      rd_r      <= REG_ZERO;
    end else begin
      ctrl_r    <= dec_ctrl_s;
      illegal_r <= dec_illegal_s;
      funct_r   <= id_funct;
      rs_r      <= id_rs;
      rt_r      <= id_rt;
      rd_r      <= id_rd;
    end
  end

  assign ex_aluop    = ctrl_r.aluop;
  assign ex_funct    = funct_r;
  assign ex_regdst   = ctrl_r.regdst;
  assign ex_alusrc   = ctrl_r.alusrc;
  assign ex_rs       = rs_r;
  assign ex_rt       = rt_r;
  assign ex_rd       = rd_r;
  assign m_memread   = ctrl_r.memread;
  assign m_memwrite  = ctrl_r.memwrite;
  assign m_branch    = ctrl_r.branch;
  assign wb_regwrite = ctrl_r.regwrite;
  assign wb_memtoreg = ctrl_r.memtoreg;
  assign ex_illegal  = illegal_r;

`ifdef ID_EX_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] bubble_cnt_r;

  // saturating stall / bubble event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r  <= CNT_ZERO;
      bubble_cnt_r <= CNT_ZERO;
    end else begin
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (bubble_s && (bubble_cnt_r != CNT_MAX)) begin
        bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end
  end

  assign stall_cnt  = stall_cnt_r;
  assign bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_control.sv
// Self-checking bench for id_ex_control: a reference decode/hazard model pushes the
// expected ID/EX contents into a scoreboard queue, popped after each clock edge.
module tb_id_ex_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [5:0] id_opcode = 6'd0;
  logic [5:0] id_funct = 6'd0;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;
  logic       flush = 1'b0;
  logic       stall, id_jump;
  logic [2:0] ex_aluop;
  logic [5:0] ex_funct;
  logic       ex_regdst, ex_alusrc;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic       m_memread, m_memwrite, m_branch, wb_regwrite, wb_memtoreg, ex_illegal;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] sb[$];
  logic [31:0] cur_m = 32'h0;
  logic [31:0] stall_cnt_m = 32'h0;
  logic [31:0] bubble_cnt_m = 32'h0;

  always #5 clk = ~clk;

  id_ex_control #(.RA_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .stall(stall), .id_jump(id_jump), .ex_aluop(ex_aluop),
    .ex_funct(ex_funct), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .m_memread(m_memread),
    .m_memwrite(m_memwrite), .m_branch(m_branch), .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg),
`ifdef ID_EX_PERF_CNT_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .ex_illegal(ex_illegal)
  );

  // {aluop, regdst, alusrc, memread, memwrite, branch, regwrite, memtoreg, illegal, rt_src}
  function automatic logic [11:0] ref_dec(input logic [5:0] op);
    case (op)
      6'b000000: ref_dec = {3'b010, 7'b1000010, 1'b0, 1'b1};
      6'b100011: ref_dec = {3'b000, 7'b0110011, 1'b0, 1'b0};
      6'b101011: ref_dec = {3'b000, 7'b0101000, 1'b0, 1'b1};
      6'b000100: ref_dec = {3'b001, 7'b0000100, 1'b0, 1'b1};
      6'b001000: ref_dec = {3'b000, 7'b0100010, 1'b0, 1'b0};
      6'b001100: ref_dec = {3'b011, 7'b0100010, 1'b0, 1'b0};
      6'b001101: ref_dec = {3'b100, 7'b0100010, 1'b0, 1'b0};
      6'b001010: ref_dec = {3'b111, 7'b0100010, 1'b0, 1'b0};
      6'b000010: ref_dec = 12'h000;
      default:   ref_dec = {3'b000, 7'b0000000, 1'b1, 1'b0};
    endcase
  endfunction

  // Packed view of all registered DUT outputs, same layout as the scoreboard entries.
  function automatic logic [31:0] obs();
    return {ex_aluop, ex_funct, ex_regdst, ex_alusrc, ex_rs, ex_rt, ex_rd,
            m_memread, m_memwrite, m_branch, wb_regwrite, wb_memtoreg, ex_illegal};
  endfunction

  // Apply one ID-stage input set, predict stall and the next ID/EX contents.
  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic fl, output logic es);
    logic [11:0] d;
    logic [31:0] nxt;
    logic bub;
    id_valid = v; id_opcode = op; id_funct = fn;
    id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
    d  = ref_dec(op);
    es = v & cur_m[5] & (cur_m[15:11] != 5'd0) & ~fl &
         ((cur_m[15:11] == rs) | ((cur_m[15:11] == rt) & d[0]));
    bub = fl | es | ~v;
    nxt = bub ? 32'h0 : {d[11:9], fn, d[8], d[7], rs, rt, rd, d[6:2], d[1]};
    sb.push_back(nxt);
    cur_m = nxt;
    if (es && stall_cnt_m != 32'hFFFF_FFFF) stall_cnt_m = stall_cnt_m + 32'd1;
    if (bub && bubble_cnt_m != 32'hFFFF_FFFF) bubble_cnt_m = bubble_cnt_m + 32'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs() !== 32'h0) begin
      $display("FAIL reset_state got=%h exp=%h", obs(), 32'h0); failures++;
    end
    checks++;
    if (stall !== 1'b0) begin
      $display("FAIL reset_stall got=%b exp=0", stall); failures++;
    end
    tick(); tick();
    #2 rst = 1'b0;
  endtask

  task automatic test_decode();
    logic [5:0] ops [8] = '{6'b000000, 6'b001101, 6'b001010, 6'b100011,
                            6'b101011, 6'b000100, 6'b001000, 6'b001100};
    logic es;
    logic [31:0] exp;
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ops[i], 6'b100000, 5'd1, 5'd2 + 5'(i), 5'd20 + 5'(i), 1'b0, es);
      #1;
      checks++;
      if (stall !== es) begin
        $display("FAIL decode_stall[%0d] got=%b exp=%b", i, stall, es); failures++;
      end
      tick();
      exp = sb.pop_front();
      checks++;
      if (obs() !== exp) begin
        $display("FAIL decode[%0d] op=%b got=%h exp=%h", i, ops[i], obs(), exp); failures++;
      end
    end
  endtask

  task automatic test_load_use();
    // {first op, first rt, second op, second rs, second rt, expected stall}
    logic [5:0] op2 [5] = '{6'b000000, 6'b101011, 6'b001000, 6'b000000, 6'b100011};
    logic [4:0] lrt [5] = '{5'd5, 5'd5, 5'd5, 5'd0, 5'd5};
    logic [4:0] rs2 [5] = '{5'd5, 5'd1, 5'd1, 5'd0, 5'd5};
    logic [4:0] rt2 [5] = '{5'd7, 5'd5, 5'd5, 5'd0, 5'd9};
    logic       st  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic es;
    logic [31:0] exp;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 6'b100011, 6'd0, 5'd2, lrt[i], 5'd0, 1'b0, es);
      tick(); void'(sb.pop_front());
      drive(1'b1, op2[i], 6'b100000, rs2[i], rt2[i], 5'd6, 1'b0, es);
      #1;
      checks++;
      if (stall !== st[i]) begin
        $display("FAIL load_use_stall[%0d] got=%b exp=%b", i, stall, st[i]); failures++;
      end
      tick();
      exp = sb.pop_front();
      checks++;
      if (obs() !== exp) begin
        $display("FAIL load_use_slot[%0d] got=%h exp=%h", i, obs(), exp); failures++;
      end
      // same instruction held in ID: must now proceed without stalling
      drive(1'b1, op2[i], 6'b100000, rs2[i], rt2[i], 5'd6, 1'b0, es);
      #1;
      checks++;
      if (stall !== 1'b0) begin
        $display("FAIL load_use_release[%0d] got=%b exp=0", i, stall); failures++;
      end
      tick();
      exp = sb.pop_front();
      checks++;
      if (obs() !== exp) begin
        $display("FAIL load_use_next[%0d] got=%h exp=%h", i, obs(), exp); failures++;
      end
    end
  endtask

  task automatic test_flush();
    logic es;
    logic [31:0] exp;
    drive(1'b1, 6'b100011, 6'd0, 5'd2, 5'd5, 5'd0, 1'b0, es);
    tick(); void'(sb.pop_front());
    drive(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd7, 5'd6, 1'b1, es);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      $display("FAIL flush_stall got=%b exp=0", stall); failures++;
    end
    tick();
    exp = sb.pop_front();
    checks++;
    if (obs() !== 32'h0 || exp !== 32'h0) begin
      $display("FAIL flush_bubble got=%h exp=%h", obs(), 32'h0); failures++;
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== bubble_cnt_m || stall_cnt !== stall_cnt_m) begin
      $display("FAIL flush_counters got=%0d/%0d exp=%0d/%0d",
               stall_cnt, bubble_cnt, stall_cnt_m, bubble_cnt_m); failures++;
    end
`endif
  endtask

  task automatic test_illegal_jump();
    logic es;
    logic [31:0] exp;
    drive(1'b1, 6'b111111, 6'b101010, 5'd3, 5'd4, 5'd8, 1'b0, es);
    #1;
    checks++;
    if (id_jump !== 1'b0) begin
      $display("FAIL illegal_jump got=%b exp=0", id_jump); failures++;
    end
    tick();
    exp = sb.pop_front();
    checks++;
    if (obs() !== exp || ex_illegal !== 1'b1 || m_memread !== 1'b0 || wb_regwrite !== 1'b0) begin
      $display("FAIL illegal_slot got=%h exp=%h", obs(), exp); failures++;
    end
    drive(1'b1, 6'b000010, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, es);
    #1;
    checks++;
    if (id_jump !== 1'b1) begin
      $display("FAIL jump_flag got=%b exp=1", id_jump); failures++;
    end
    tick();
    exp = sb.pop_front();
    checks++;
    if (obs() !== exp || ex_illegal !== 1'b0) begin
      $display("FAIL jump_slot got=%h exp=%h", obs(), exp); failures++;
    end
    drive(1'b0, 6'b000010, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, es);
    #1;
    checks++;
    if (id_jump !== 1'b0) begin
      $display("FAIL jump_invalid got=%b exp=0", id_jump); failures++;
    end
    tick();
    exp = sb.pop_front();
    checks++;
    if (obs() !== exp) begin
      $display("FAIL invalid_bubble got=%h exp=%h", obs(), exp); failures++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                             6'b001100, 6'b001101, 6'b001010, 6'b000010, 6'b111111};
    logic es;
    logic [31:0] exp;
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 7) != 0), ops[$urandom_range(0, 9)], 6'($urandom_range(0, 63)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 9) == 0), es);
      #1;
      checks++;
      if (stall !== es) begin
        $display("FAIL b2b_stall[%0d] got=%b exp=%b", i, stall, es); failures++;
      end
      tick();
      exp = sb.pop_front();
      checks++;
      if (obs() !== exp) begin
        $display("FAIL b2b_slot[%0d] got=%h exp=%h", i, obs(), exp); failures++;
      end
`ifdef ID_EX_PERF_CNT_EN
      checks++;
      if (stall_cnt !== stall_cnt_m || bubble_cnt !== bubble_cnt_m) begin
        $display("FAIL b2b_counters[%0d] got=%0d/%0d exp=%0d/%0d", i,
                 stall_cnt, bubble_cnt, stall_cnt_m, bubble_cnt_m); failures++;
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    logic es;
    logic [31:0] exp;
    drive(1'b1, 6'b100011, 6'd0, 5'd2, 5'd5, 5'd0, 1'b0, es);
    tick(); void'(sb.pop_front());
    drive(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd7, 5'd6, 1'b0, es);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      $display("FAIL pre_reset_stall got=%b exp=1", stall); failures++;
    end
    sb.delete();
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 32'h0 || stall !== 1'b0) begin
      $display("FAIL async_reset got=%h/%b exp=%h/0", obs(), stall, 32'h0); failures++;
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 32'h0 || bubble_cnt !== 32'h0) begin
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, bubble_cnt); failures++;
    end
`endif
    #1 rst = 1'b0;
    cur_m = 32'h0; stall_cnt_m = 32'h0; bubble_cnt_m = 32'h0;
    drive(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd7, 5'd6, 1'b0, es);
    tick();
    exp = sb.pop_front();
    checks++;
    if (obs() !== exp) begin
      $display("FAIL post_reset_load got=%h exp=%h", obs(), exp); failures++;
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_flush();
    test_illegal_jump();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
